// File: rtl/register_bank_pair_if.sv
// Operand/update bus of the paired register bank: byte and pair writes,
// pair inc/dec, two byte reads and one pair read.
interface register_bank_pair_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REGS   = 8
);
  localparam int unsigned AW = $clog2(NUM_REGS);
  localparam int unsigned PW = (AW > 1) ? AW - 1 : 1;

  logic [DATA_WIDTH-1:0]   dataIn;
  logic                    writeEnable;
  logic [AW-1:0]           writeReg;
  logic [2*DATA_WIDTH-1:0] dataIn16;
  logic                    writeEnable16;
  logic [PW-1:0]           writePair;
  logic [1:0]              incDec;
  logic [PW-1:0]           incDecPair;
  logic [AW-1:0]           readRegA;
  logic [AW-1:0]           readRegB;
  logic [DATA_WIDTH-1:0]   dataOutA;
  logic [DATA_WIDTH-1:0]   dataOutB;
  logic [2*DATA_WIDTH-1:0] dataOut16;
  logic                    pairWrap;

  modport master (
    output dataIn, writeEnable, writeReg, dataIn16, writeEnable16, writePair,
           incDec, incDecPair, readRegA, readRegB,
    input  dataOutA, dataOutB, dataOut16, pairWrap
  );

  modport slave (
    input  dataIn, writeEnable, writeReg, dataIn16, writeEnable16, writePair,
           incDec, incDecPair, readRegA, readRegB,
    output dataOutA, dataOutB, dataOut16, pairWrap
  );
endinterface

// File: rtl/register_bank_pair.sv
// Two-read-port register file whose even/odd registers pair into double-width
// registers, with byte write, pair write and single-cycle pair inc/dec.
module register_bank_pair #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           NUM_REGS    = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic               clk,
  input  logic               reset,
  register_bank_pair_if.slave bus
);
  localparam int unsigned AW        = $clog2(NUM_REGS);
  localparam int unsigned PW        = (AW > 1) ? AW - 1 : 1;
  localparam int unsigned NUM_PAIRS = NUM_REGS / 2;

  typedef logic [DATA_WIDTH-1:0]   word_t;
  typedef logic [2*DATA_WIDTH-1:0] pairWord_t;

  word_t     regs     [NUM_REGS];
  word_t     regsNext [NUM_REGS];
  logic      wrapNext;
  logic      pairApply;
  logic      byteApply;
  logic      incReq;
  logic      incApply;
  pairWord_t incOld;
  pairWord_t incNew;

  // Even register of a pair is the high half.
  function automatic logic [AW-1:0] hiReg(input logic [PW-1:0] p);
    logic [PW:0] t;
    t = {p, 1'b0};
    return t[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] loReg(input logic [PW-1:0] p);
    logic [PW:0] t;
    t = {p, 1'b1};
    return t[AW-1:0];
  endfunction

  function automatic logic [PW-1:0] pairOf(input logic [AW-1:0] r);
    logic [PW:0] t;
    t = '0;
    t[AW-1:0] = r;
    return t[PW:1];
  endfunction

  // Only relevant for NUM_REGS=2, where the 1-bit pair select can exceed pair 0.
  function automatic logic pairValid(input logic [PW-1:0] p);
    return 32'(p) < NUM_PAIRS;
  endfunction

  always_comb begin
    regsNext  = regs;
    wrapNext  = 1'b0;
    pairApply = bus.writeEnable16 && pairValid(bus.writePair);
    byteApply = bus.writeEnable &&
                !(pairApply && (pairOf(bus.writeReg) == bus.writePair));
    incReq    = ((bus.incDec == 2'b01) || (bus.incDec == 2'b10)) &&
                pairValid(bus.incDecPair);
    // Any write touching the inc/dec pair cancels the inc/dec, even a
    // byte write that itself loses to a pair write.
    incApply  = incReq &&
                !(pairApply && (bus.writePair == bus.incDecPair)) &&
                !(bus.writeEnable && (pairOf(bus.writeReg) == bus.incDecPair));
    incOld    = {regs[hiReg(bus.incDecPair)], regs[loReg(bus.incDecPair)]};
    incNew    = (bus.incDec == 2'b01) ? incOld + pairWord_t'(1)
                                      : incOld - pairWord_t'(1);

    if (incApply) begin
      regsNext[hiReg(bus.incDecPair)] = incNew[2*DATA_WIDTH-1:DATA_WIDTH];
      regsNext[loReg(bus.incDecPair)] = incNew[DATA_WIDTH-1:0];
      wrapNext = (bus.incDec == 2'b01) ? (incOld == '1) : (incOld == '0);
    end
    if (byteApply) begin
      regsNext[bus.writeReg] = bus.dataIn;
    end
    if (pairApply) begin
      regsNext[hiReg(bus.writePair)] = bus.dataIn16[2*DATA_WIDTH-1:DATA_WIDTH];
      regsNext[loReg(bus.writePair)] = bus.dataIn16[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VALUE;
      end
      bus.dataOutA  <= '0;
      bus.dataOutB  <= '0;
      bus.dataOut16 <= '0;
      bus.pairWrap  <= 1'b0;
    end else begin
      regs          <= regsNext;
      bus.dataOutA  <= regsNext[bus.readRegA];
      bus.dataOutB  <= regsNext[bus.readRegB];
      bus.dataOut16 <= {regsNext[hiReg(pairOf(bus.readRegA))],
                        regsNext[loReg(pairOf(bus.readRegA))]};
      bus.pairWrap  <= wrapNext;
    end
  end
endmodule

// File: tb/tb_register_bank_pair.sv
// Bench for register_bank_pair: directed vector table, multi-cycle sequences,
// randomized traffic against an arithmetic reference model, and a 16-bit/4-reg build.
module tb_register_bank_pair;
  logic clk = 1'b0;
  logic rst1;
  logic rst2;
  always #5 clk = ~clk;

  register_bank_pair_if #(.DATA_WIDTH(8),  .NUM_REGS(8)) bus1 ();
  register_bank_pair_if #(.DATA_WIDTH(16), .NUM_REGS(4)) bus2 ();

  register_bank_pair #(.DATA_WIDTH(8), .NUM_REGS(8), .RESET_VALUE(8'h00)) dut1 (
    .clk(clk), .reset(rst1), .bus(bus1)
  );
  register_bank_pair #(.DATA_WIDTH(16), .NUM_REGS(4), .RESET_VALUE(16'h0000)) dut2 (
    .clk(clk), .reset(rst2), .bus(bus2)
  );

  typedef struct {
    int unsigned rst, we, wr, d, we16, wp, d16, id, idp, ra, rb;
    int unsigned eA, eB, e16, eW;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int m [8];

  function automatic vec_t mkv(int unsigned rst, we, wr, d, we16, wp, d16, id, idp,
                               ra, rb, eA, eB, e16, eW);
    vec_t v;
    v.rst = rst; v.we = we; v.wr = wr; v.d = d; v.we16 = we16; v.wp = wp;
    v.d16 = d16; v.id = id; v.idp = idp; v.ra = ra; v.rb = rb;
    v.eA = eA; v.eB = eB; v.e16 = e16; v.eW = eW;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic apply1(input vec_t v, input string tag);
    rst1                = 1'(v.rst);
    bus1.writeEnable    = 1'(v.we);
    bus1.writeReg       = 3'(v.wr);
    bus1.dataIn         = 8'(v.d);
    bus1.writeEnable16  = 1'(v.we16);
    bus1.writePair      = 2'(v.wp);
    bus1.dataIn16       = 16'(v.d16);
    bus1.incDec         = 2'(v.id);
    bus1.incDecPair     = 2'(v.idp);
    bus1.readRegA       = 3'(v.ra);
    bus1.readRegB       = 3'(v.rb);
    @(posedge clk);
    #1;
    check({tag, ".A"},    64'(bus1.dataOutA),  64'(v.eA));
    check({tag, ".B"},    64'(bus1.dataOutB),  64'(v.eB));
    check({tag, ".P16"},  64'(bus1.dataOut16), 64'(v.e16));
    check({tag, ".wrap"}, 64'(bus1.pairWrap),  64'(v.eW));
  endtask

  task automatic apply2(input vec_t v, input string tag);
    rst2                = 1'(v.rst);
    bus2.writeEnable    = 1'(v.we);
    bus2.writeReg       = 2'(v.wr);
    bus2.dataIn         = 16'(v.d);
    bus2.writeEnable16  = 1'(v.we16);
    bus2.writePair      = 1'(v.wp);
    bus2.dataIn16       = 32'(v.d16);
    bus2.incDec         = 2'(v.id);
    bus2.incDecPair     = 1'(v.idp);
    bus2.readRegA       = 2'(v.ra);
    bus2.readRegB       = 2'(v.rb);
    @(posedge clk);
    #1;
    check({tag, ".A"},    64'(bus2.dataOutA),  64'(v.eA));
    check({tag, ".B"},    64'(bus2.dataOutB),  64'(v.eB));
    check({tag, ".P32"},  64'(bus2.dataOut16), 64'(v.e16));
    check({tag, ".wrap"}, 64'(bus2.pairWrap),  64'(v.eW));
  endtask

  // Reference: registers as integers, pairs as hi*256+lo, inc/dec modulo 65536.
  task automatic predict(input vec_t vin, output vec_t vout);
    int  nx [8];
    int  pv;
    int  pn;
    int  base;
    bit  doInc;
    vout = vin;
    if (vin.rst != 0) begin
      foreach (m[i]) m[i] = 0;
      vout.eA = 0; vout.eB = 0; vout.e16 = 0; vout.eW = 0;
      return;
    end
    foreach (nx[i]) nx[i] = m[i];
    vout.eW = 0;
    doInc = (vin.id == 1 || vin.id == 2) &&
            !(vin.we16 != 0 && vin.wp == vin.idp) &&
            !(vin.we != 0 && vin.wr / 2 == vin.idp);
    if (doInc) begin
      pv = m[2*vin.idp] * 256 + m[2*vin.idp+1];
      if (vin.id == 1) begin
        pn = (pv + 1) % 65536;
        vout.eW = (pv == 65535) ? 1 : 0;
      end else begin
        pn = (pv + 65535) % 65536;
        vout.eW = (pv == 0) ? 1 : 0;
      end
      nx[2*vin.idp]   = pn / 256;
      nx[2*vin.idp+1] = pn % 256;
    end
    if (vin.we != 0 && !(vin.we16 != 0 && vin.wr / 2 == vin.wp)) nx[vin.wr] = int'(vin.d);
    if (vin.we16 != 0) begin
      nx[2*vin.wp]   = int'(vin.d16 / 256);
      nx[2*vin.wp+1] = int'(vin.d16 % 256);
    end
    foreach (m[i]) m[i] = nx[i];
    base     = int'(vin.ra / 2) * 2;
    vout.eA  = nx[vin.ra];
    vout.eB  = nx[vin.rb];
    vout.e16 = nx[base] * 256 + nx[base+1];
  endtask

  initial begin
    vec_t tbl [$];
    vec_t v;
    vec_t e;
    int   sel;

    rst1 = 1'b1; rst2 = 1'b1;
    bus1.writeEnable = 1'b0; bus1.writeReg = '0; bus1.dataIn = '0;
    bus1.writeEnable16 = 1'b0; bus1.writePair = '0; bus1.dataIn16 = '0;
    bus1.incDec = '0; bus1.incDecPair = '0; bus1.readRegA = '0; bus1.readRegB = '0;
    bus2.writeEnable = 1'b0; bus2.writeReg = '0; bus2.dataIn = '0;
    bus2.writeEnable16 = 1'b0; bus2.writePair = '0; bus2.dataIn16 = '0;
    bus2.incDec = '0; bus2.incDecPair = '0; bus2.readRegA = '0; bus2.readRegB = '0;

    //            rst we wr d     we16 wp d16      id idp ra rb  eA     eB     e16      eW
    tbl.push_back(mkv(1, 0, 0, 0,     0, 0, 0,       0, 0, 0, 0, 0,     0,     0,       0));
    tbl.push_back(mkv(0, 0, 0, 0,     1, 0, 'hDEAD,  0, 0, 0, 1, 'hDE,  'hAD,  'hDEAD,  0));
    tbl.push_back(mkv(0, 0, 0, 0,     1, 1, 'hBEEF,  0, 0, 2, 3, 'hBE,  'hEF,  'hBEEF,  0));
    tbl.push_back(mkv(0, 0, 0, 0,     1, 2, 'hBABA,  0, 0, 4, 5, 'hBA,  'hBA,  'hBABA,  0));
    tbl.push_back(mkv(0, 0, 0, 0,     1, 3, 'hBABE,  0, 0, 6, 7, 'hBA,  'hBE,  'hBABE,  0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0,       0, 0, 0, 7, 'hDE,  'hBE,  'hDEAD,  0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0,       0, 0, 1, 6, 'hAD,  'hBA,  'hDEAD,  0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0,       0, 0, 2, 5, 'hBE,  'hBA,  'hBEEF,  0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0,       0, 0, 3, 4, 'hEF,  'hBA,  'hBEEF,  0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0,       0, 0, 4, 3, 'hBA,  'hEF,  'hBABA,  0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0,       0, 0, 5, 2, 'hBA,  'hBE,  'hBABA,  0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0,       0, 0, 6, 1, 'hBA,  'hAD,  'hBABE,  0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0,       0, 0, 7, 0, 'hBE,  'hDE,  'hBABE,  0));
    tbl.push_back(mkv(0, 0, 0, 0,     1, 2, 'h00FF,  0, 0, 4, 5, 'h00,  'hFF,  'h00FF,  0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0,       1, 2, 4, 5, 'h01,  'h00,  'h0100,  0));
    tbl.push_back(mkv(0, 0, 0, 0,     1, 2, 'hFFFF,  0, 0, 4, 5, 'hFF,  'hFF,  'hFFFF,  0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0,       1, 2, 4, 5, 'h00,  'h00,  'h0000,  1));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0,       0, 2, 4, 5, 'h00,  'h00,  'h0000,  0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0,       2, 2, 4, 5, 'hFF,  'hFF,  'hFFFF,  1));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0,       3, 2, 4, 5, 'hFF,  'hFF,  'hFFFF,  0));
    tbl.push_back(mkv(0, 1, 3, 'h99,  1, 1, 'h1234,  1, 1, 2, 3, 'h12,  'h34,  'h1234,  0));
    tbl.push_back(mkv(0, 1, 0, 'h11,  1, 0, 'hCAFE,  0, 0, 0, 1, 'hCA,  'hFE,  'hCAFE,  0));
    tbl.push_back(mkv(0, 1, 0, 'h77,  0, 0, 0,       1, 3, 6, 0, 'hBA,  'h77,  'hBABF,  0));
    tbl.push_back(mkv(0, 1, 5, 'h5A,  0, 0, 0,       1, 2, 5, 5, 'h5A,  'h5A,  'hFF5A,  0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0,       1, 3, 7, 6, 'hC0,  'hBA,  'hBAC0,  0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0,       1, 3, 7, 6, 'hC1,  'hBA,  'hBAC1,  0));
    tbl.push_back(mkv(1, 0, 0, 0,     1, 1, 'h5555,  1, 3, 2, 3, 0,     0,     0,       0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0,       0, 0, 6, 3, 0,     0,     0,       0));
    tbl.push_back(mkv(0, 0, 0, 0,     0, 0, 0,       1, 3, 6, 7, 'h00,  'h01,  'h0001,  0));

    foreach (tbl[k]) apply1(tbl[k], $sformatf("tbl%0d", k));

    for (int i = 0; i < 8; i++) begin
      apply1(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), $sformatf("iso%0d.rst", i));
      apply1(mkv(0, 1, i, 'hFF, 0, 0, 0, 0, 0, i, i, 'hFF, 'hFF,
                 (i % 2 == 0) ? 'hFF00 : 'h00FF, 0), $sformatf("iso%0d.wr", i));
      for (int j = 0; j < 8; j++) begin
        apply1(mkv(0, 0, 0, 'hF0, 0, 0, 0, 0, 0, j, j,
                   (j == i) ? 'hFF : 0, (j == i) ? 'hFF : 0,
                   (j / 2 != i / 2) ? 0 : ((i % 2 == 0) ? 'hFF00 : 'h00FF), 0),
               $sformatf("iso%0d.rd%0d", i, j));
      end
    end

    v = mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    predict(v, e);
    apply1(e, "rnd.rst");
    for (int n = 0; n < 400; n++) begin
      v.rst  = ($urandom_range(0, 31) == 0) ? 1 : 0;
      v.we   = $urandom_range(0, 1);
      v.wr   = $urandom_range(0, 7);
      v.d    = $urandom_range(0, 255);
      v.we16 = ($urandom_range(0, 2) == 0) ? 1 : 0;
      v.wp   = $urandom_range(0, 3);
      sel    = int'($urandom_range(0, 3));
      v.d16  = (sel == 0) ? 0 : (sel == 1) ? 'hFFFF : $urandom_range(0, 65535);
      v.id   = $urandom_range(0, 3);
      v.idp  = $urandom_range(0, 3);
      v.ra   = $urandom_range(0, 7);
      v.rb   = $urandom_range(0, 7);
      predict(v, e);
      apply1(e, $sformatf("rnd%0d", n));
    end

    //         rst we wr d       we16 wp d16          id idp ra rb  eA      eB      e16           eW
    apply2(mkv(1, 0, 0, 0,       0, 0, 0,           0, 0, 0, 0, 0,      0,      0,            0), "w16.rst");
    apply2(mkv(0, 0, 0, 0,       1, 1, 'hFFFFFFFF,  0, 0, 2, 3, 'hFFFF, 'hFFFF, 'hFFFFFFFF,   0), "w16.ld");
    apply2(mkv(0, 0, 0, 0,       0, 0, 0,           1, 1, 2, 3, 0,      0,      0,            1), "w16.incwrap");
    apply2(mkv(0, 0, 0, 0,       1, 1, 'h0000FFFF,  0, 0, 2, 3, 0,      'hFFFF, 'h0000FFFF,   0), "w16.ld2");
    apply2(mkv(0, 0, 0, 0,       0, 0, 0,           1, 1, 3, 2, 0,      'h0001, 'h00010000,   0), "w16.carry");
    apply2(mkv(1, 1, 0, 'hABCD,  1, 0, 'h12345678,  1, 1, 0, 2, 0,      0,      0,            0), "w16.midrst");
    apply2(mkv(0, 0, 0, 0,       0, 0, 0,           0, 0, 2, 1, 0,      0,      0,            0), "w16.post");
    apply2(mkv(0, 0, 0, 0,       0, 0, 0,           2, 0, 0, 1, 'hFFFF, 'hFFFF, 'hFFFFFFFF,   1), "w16.decwrap");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/register_bank_pair.md
# register_bank_pair

Parametrised successor to the CPU register bank: a 2-port-read register file whose registers pair up into double-width registers (BC/DE/HL-style), with byte write, pair write and in-place pair increment/decrement. It sits in the CPU core between the instruction decoder/ALU and the address path. It supplies two byte operands and one pair value per cycle, and gives the address path single-cycle HL+/HL-/SP±1 updates.

## Interface
- DATA_WIDTH, 8, width of one register
- NUM_REGS, 8, register count; even power of two, at least 2
- RESET_VALUE, 0, value loaded into every register on reset
- AW (derived, not overridable) = log2(NUM_REGS); PW = AW-1, minimum 1

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- dataIn  in  DATA_WIDTH  byte write data
- writeEnable  in  1  byte write of dataIn into registers[writeReg]
- writeReg  in  AW  byte write target
- dataIn16  in  2*DATA_WIDTH  pair write data
- writeEnable16  in  1  pair write of dataIn16 into pair writePair
- writePair  in  PW  pair write target
- incDec  in  2  00 none, 01 increment pair, 10 decrement pair, 11 none (reserved)
- incDecPair  in  PW  pair targeted by incDec
- readRegA  in  AW  read select A
- readRegB  in  AW  read select B
- dataOutA  out  DATA_WIDTH  registered registers[readRegA]
- dataOutB  out  DATA_WIDTH  registered registers[readRegB]
- dataOut16  out  2*DATA_WIDTH  registered pair containing readRegA (pair index readRegA>>1)
- pairWrap  out  1  registered; 1 when the inc/dec applied on the previous edge wrapped

## Operation
- Pair p is {registers[2p], registers[2p+1]}. The even register is the high half: registers 0=0xDE and 1=0xAD give pair 0 = 0xDEAD.
- Increment and decrement are modulo 2^(2*DATA_WIDTH). Carry/borrow propagates from the low register into the high register. Wrap conditions: 0xFFFF+1 gives 0x0000; 0x0000-1 gives 0xFFFF.
- All requested operations in a cycle apply on the same edge when their targets are disjoint.
- Conflict priority:
  - Pair write beats a byte write to either register of the same pair.
  - Any write (byte or pair) touching the pair targeted by inc/dec suppresses that inc/dec entirely. In that case pairWrap is 0.
- Reads use write-through: the outputs registered at edge N show the register contents after all updates at edge N, including writes, inc/dec and reset values.
- readRegA and readRegB may be equal, and may equal any write target; each output still follows the write-through rule.
- Reset has priority over everything:
  - Every register loads RESET_VALUE.
  - dataOutA, dataOutB, dataOut16 and pairWrap load 0.
  - All writes and inc/dec in that cycle are discarded.
  - Reset asserted in the middle of a sequence has no effect on later cycles beyond this.
- No state machine. The storage array plus output registers are the only state. There is no busy or stall: every cycle can accept a new operation set.

## Timing
- Latency is 1 cycle: inputs sampled at edge N, outputs valid after edge N and held until edge N+1.
- Outputs change only on clk edges. There is no combinational path from inputs to outputs.
- pairWrap is high for exactly the one cycle after the wrapping edge. It is 0 in every cycle without an applied wrap.
- Back-to-back inc/dec on the same pair advances the pair by one per cycle.

## Test plan
- Byte isolation: reset; for each i, write 0xFF to register i. Required: next cycle dataOutA=0xFF with readRegA=i, and every other register reads 0x00; after holding writeEnable=0 with dataIn=0xF0, register i still reads 0xFF.
- Pair readout: preload DE AD BE EF BA BA BA BE and sweep readRegA 0..7. Required: dataOut16 reads 0xDEAD, 0xDEAD, 0xBEEF, 0xBEEF, 0xBABA, 0xBABA, 0xBABE, 0xBABE. Sweeping readRegB at the same time gives the matching individual bytes.
- Inc/dec and wrap:
  - Pair 2 = 0x00FF, increment: pair reads 0x0100 and pairWrap=0.
  - Pair 2 = 0xFFFF, increment: pair reads 0x0000 and pairWrap=1 for one cycle.
  - Pair 2 = 0x0000, decrement: pair reads 0xFFFF and pairWrap=1.
- Conflicts: all three requested in one cycle — pair write 0x1234 to pair 1, byte write 0x99 to register 3, increment of pair 1. Required: pair 1 reads 0x1234 and pairWrap=0. Separately, a byte write to register 0 together with an increment of pair 3 applies both.
- Write-through: write 0x5A to register 5 with readRegA=readRegB=5 in the same cycle. Required: both outputs read 0x5A after that edge.
- Reset mid-operation: assert reset together with a pair write and an increment. Required: all registers read RESET_VALUE, all outputs 0, and the next operation behaves normally. Repeat with DATA_WIDTH=16, NUM_REGS=4 to check 32-bit pairs wrap at 0xFFFFFFFF.
